// File: rtl/link_pkg.sv
// Shared definitions for the link bring-up sequencer: state encoding and retry width.
package link_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_CLEAR  = 3'd1;
  localparam logic [2:0] ST_SETTLE = 3'd2;
  localparam logic [2:0] ST_ARM    = 3'd3;
  localparam logic [2:0] ST_RUN    = 3'd4;
  localparam logic [2:0] ST_FAULT  = 3'd5;

  localparam int RETRY_W = 4;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_CLEAR  = ST_CLEAR,
    S_SETTLE = ST_SETTLE,
    S_ARM    = ST_ARM,
    S_RUN    = ST_RUN,
    S_FAULT  = ST_FAULT
  } state_t;

endpackage

// File: rtl/link_sequencer_if.sv
// Control/status bundle between the link sequencer and its controller / transmitter-receiver pair.
interface link_sequencer_if #(
  parameter int ERR_W = 8
);
  import link_pkg::*;

  // start/stop/valid are level flags sampled every rising edge; there is no
  // ready/backpressure path, the sequencer consumes them unconditionally.
  logic               start;
  logic               stop;
  logic               valid;
  logic               ctr_clr;
  logic               ctr_en;
  logic               conv_en_n;
  logic               locked;
  logic               fault;
  logic               busy;
  logic [RETRY_W-1:0] retry_cnt;
  logic [ERR_W-1:0]   drop_cnt;
  state_t             dbg_state;

  modport master (
    input  start, stop, valid,
    output ctr_clr, ctr_en, conv_en_n, locked, fault, busy, retry_cnt, drop_cnt, dbg_state
  );

  modport slave (
    output start, stop, valid,
    input  ctr_clr, ctr_en, conv_en_n, locked, fault, busy, retry_cnt, drop_cnt, dbg_state
  );

endinterface

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/link_sequencer.sv
// Moore sequencer: clear, settle, arm converters, wait for valid; monitors the
// running link, retries bring-up a bounded number of times, then latches fault.
module link_sequencer
  import link_pkg::*;
#(
  parameter int CLR_CYCLES    = 4,
  parameter int SETTLE_CYCLES = 5,
  parameter int LOCK_TIMEOUT  = 16,
  parameter int DROP_LIMIT    = 3,
  parameter int MAX_RETRIES   = 3,
  parameter int ERR_W         = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  link_sequencer_if.master  bus
);

  localparam int MAX_AB = (CLR_CYCLES > SETTLE_CYCLES) ? CLR_CYCLES : SETTLE_CYCLES;
  localparam int MAX_CD = (LOCK_TIMEOUT > DROP_LIMIT) ? LOCK_TIMEOUT : DROP_LIMIT;
  localparam int MAX_T  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int TW     = $clog2(MAX_T) + 1;
  localparam logic [RETRY_W-1:0] MAX_R = RETRY_W'(MAX_RETRIES);

  state_t             state, next_state;
  logic [TW-1:0]      timer, timer_nxt;
  logic [RETRY_W-1:0] retry_cnt, retry_nxt;
  logic               lock_fail;
  logic               drop_clr, drop_en;
  logic               ctr_clr_q, ctr_en_q, conv_en_n_q, locked_q, fault_q, busy_q;

  // The single state timer counts down to zero; a state lasts reload+1 cycles.
  function automatic logic [TW-1:0] reload(state_t s);
    case (s)
      S_CLEAR:  return TW'(CLR_CYCLES - 1);
      S_SETTLE: return TW'(SETTLE_CYCLES - 1);
      S_ARM:    return TW'(LOCK_TIMEOUT - 1);
      S_RUN:    return TW'(DROP_LIMIT - 1);
      default:  return '0;
    endcase
  endfunction

  always_comb begin
    next_state = state;
    timer_nxt  = timer;
    retry_nxt  = retry_cnt;
    lock_fail  = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.start) begin
          next_state = S_CLEAR;
          retry_nxt  = '0;
        end
      end
      S_CLEAR: begin
        if (timer == '0) next_state = S_SETTLE;
        else             timer_nxt  = timer - TW'(1);
      end
      S_SETTLE: begin
        if (timer == '0) next_state = S_ARM;
        else             timer_nxt  = timer - TW'(1);
      end
      S_ARM: begin
        if (bus.valid)        next_state = S_RUN;
        else if (timer == '0) lock_fail  = 1'b1;
        else                  timer_nxt  = timer - TW'(1);
      end
      S_RUN: begin
        // Timer here tracks the remaining tolerance of consecutive low cycles.
        if (bus.valid)        timer_nxt = reload(S_RUN);
        else if (timer == '0) lock_fail = 1'b1;
        else                  timer_nxt = timer - TW'(1);
      end
      S_FAULT: begin
        next_state = S_FAULT;
      end
      default: begin
        next_state = S_IDLE;
      end
    endcase

    if (lock_fail) begin
      if (retry_cnt < MAX_R) begin
        retry_nxt  = retry_cnt + RETRY_W'(1);
        next_state = S_CLEAR;
      end else begin
        next_state = S_FAULT;
      end
    end

    if (bus.stop) begin
      next_state = S_IDLE;
      retry_nxt  = retry_cnt;
    end

    if (next_state != state) timer_nxt = reload(next_state);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      timer       <= '0;
      retry_cnt   <= '0;
      ctr_clr_q   <= 1'b0;
      ctr_en_q    <= 1'b0;
      conv_en_n_q <= 1'b1;
      locked_q    <= 1'b0;
      fault_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state       <= next_state;
      timer       <= timer_nxt;
      retry_cnt   <= retry_nxt;
      // Outputs are registered from the next state so they change with the state register.
      ctr_clr_q   <= (next_state == S_CLEAR);
      ctr_en_q    <= (next_state == S_SETTLE) || (next_state == S_ARM) || (next_state == S_RUN);
      conv_en_n_q <= !((next_state == S_ARM) || (next_state == S_RUN));
      locked_q    <= (next_state == S_RUN);
      fault_q     <= (next_state == S_FAULT);
      busy_q      <= (next_state != S_IDLE) && (next_state != S_FAULT);
    end
  end

  // Dropouts count even on a cycle where stop wins the transition.
  assign drop_en  = (state == S_RUN) && !bus.valid;
  assign drop_clr = (state == S_IDLE) && bus.start && !bus.stop;

  sat_counter #(.W(ERR_W)) u_drop_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (drop_clr),
    .en    (drop_en),
    .count (bus.drop_cnt)
  );

  assign bus.ctr_clr   = ctr_clr_q;
  assign bus.ctr_en    = ctr_en_q;
  assign bus.conv_en_n = conv_en_n_q;
  assign bus.locked    = locked_q;
  assign bus.fault     = fault_q;
  assign bus.busy      = busy_q;
  assign bus.retry_cnt = retry_cnt;
  assign bus.dbg_state = state;

endmodule

// File: tb/tb_link_sequencer.sv
// Bench for link_sequencer: two instances (ERR_W=8 and ERR_W=2) share stimulus;
// expected output vectors are queued per cycle and compared after each edge.
module tb_link_sequencer;

  logic clk;
  logic rst_n;
  logic start, stop, valid;

  int checks   = 0;
  int failures = 0;

  logic [22:0] exp_q[$];

  link_sequencer_if #(.ERR_W(8)) bus8 ();
  link_sequencer_if #(.ERR_W(2)) bus2 ();

  assign bus8.start = start;
  assign bus8.stop  = stop;
  assign bus8.valid = valid;
  assign bus2.start = start;
  assign bus2.stop  = stop;
  assign bus2.valid = valid;

  link_sequencer #(.ERR_W(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
  link_sequencer #(.ERR_W(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected vector from the per-state output table:
  // {state, ctr_clr, ctr_en, conv_en_n, locked, fault, busy, retry, drop8, drop2}
  function automatic logic [22:0] exp_vec(int st, int retry, int drop);
    logic [2:0] s;
    logic [3:0] r;
    logic [7:0] d8;
    logic [1:0] d2;
    s  = st[2:0];
    r  = retry[3:0];
    d8 = drop[7:0];
    d2 = (drop > 3) ? 2'd3 : drop[1:0];
    return {s, (st == 1), (st == 2 || st == 3 || st == 4), !(st == 3 || st == 4),
            (st == 4), (st == 5), !(st == 0 || st == 5), r, d8, d2};
  endfunction

  function automatic logic [22:0] obs_vec();
    return {bus8.dbg_state, bus8.ctr_clr, bus8.ctr_en, bus8.conv_en_n, bus8.locked,
            bus8.fault, bus8.busy, bus8.retry_cnt, bus8.drop_cnt, bus2.drop_cnt};
  endfunction

  task automatic check_eq(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push_exp(int st, int retry, int drop);
    exp_q.push_back(exp_vec(st, retry, drop));
  endtask

  task automatic compare(string tag);
    logic [22:0] e;
    if (exp_q.size() == 0) begin
      check_eq({tag, "_empty_q"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check_eq(tag, {9'd0, obs_vec()}, {9'd0, e});
    end
  endtask

  task automatic expect_seq(string tag, int st, int n, int retry, int drop);
    for (int i = 0; i < n; i++) begin
      push_exp(st, retry, drop);
      cyc();
      compare(tag);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    stop  = 1'b0;
    valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    push_exp(0, 0, 0);
    compare("reset");
    rst_n = 1'b1;
    expect_seq("idle_after_reset", 0, 2, 0, 0);

    // Basic bring-up with valid high
    valid = 1'b1;
    start = 1'b1;
    expect_seq("start_clear", 1, 1, 0, 0);
    start = 1'b0;
    expect_seq("clear", 1, 3, 0, 0);
    expect_seq("settle", 2, 5, 0, 0);
    expect_seq("arm", 3, 1, 0, 0);
    expect_seq("run", 4, 2, 0, 0);

    // Short dropout then a full DROP_LIMIT run forcing re-lock
    valid = 1'b0;
    expect_seq("drop1", 4, 1, 0, 1);
    expect_seq("drop2", 4, 1, 0, 2);
    valid = 1'b1;
    expect_seq("drop_hold", 4, 2, 0, 2);
    valid = 1'b0;
    expect_seq("drop3", 4, 1, 0, 3);
    expect_seq("drop4", 4, 1, 0, 4);
    expect_seq("relock_clear", 1, 1, 1, 5);
    valid = 1'b1;
    expect_seq("relock_clear", 1, 3, 1, 5);
    expect_seq("relock_settle", 2, 5, 1, 5);
    expect_seq("relock_arm", 3, 1, 1, 5);
    expect_seq("relock_run", 4, 1, 1, 5);

    // stop on the DROP_LIMIT-th low cycle: stop wins, drop still counts
    valid = 1'b0;
    expect_seq("pre_stop_drop", 4, 1, 1, 6);
    expect_seq("pre_stop_drop", 4, 1, 1, 7);
    stop = 1'b1;
    expect_seq("stop_vs_drop", 0, 1, 1, 8);
    stop  = 1'b0;
    valid = 1'b1;
    expect_seq("idle_hold_counts", 0, 1, 1, 8);

    // Fresh start clears counters; toggling dropouts saturate the narrow counter
    start = 1'b1;
    expect_seq("restart_clear", 1, 1, 0, 0);
    start = 1'b0;
    expect_seq("restart_clear", 1, 3, 0, 0);
    expect_seq("restart_settle", 2, 5, 0, 0);
    expect_seq("restart_arm", 3, 1, 0, 0);
    expect_seq("restart_run", 4, 1, 0, 0);
    for (int i = 0; i < 5; i++) begin
      valid = 1'b0;
      expect_seq("toggle_low", 4, 1, 0, i + 1);
      valid = 1'b1;
      expect_seq("toggle_high", 4, 1, 0, i + 1);
    end
    stop = 1'b1;
    expect_seq("stop_run", 0, 1, 0, 5);
    stop = 1'b0;

    // valid never arrives: three retries then sticky fault
    valid = 1'b0;
    start = 1'b1;
    expect_seq("nolock_clear", 1, 1, 0, 0);
    start = 1'b0;
    expect_seq("nolock_clear", 1, 3, 0, 0);
    expect_seq("nolock_settle", 2, 5, 0, 0);
    expect_seq("nolock_arm", 3, 16, 0, 0);
    for (int r = 1; r <= 3; r++) begin
      expect_seq("retry_clear", 1, 4, r, 0);
      expect_seq("retry_settle", 2, 5, r, 0);
      expect_seq("retry_arm", 3, 16, r, 0);
    end
    start = 1'b1;
    expect_seq("fault_sticky", 5, 3, 3, 0);
    start = 1'b0;
    stop  = 1'b1;
    expect_seq("fault_stop", 0, 1, 3, 0);
    stop = 1'b0;

    // valid arrives on the cycle that would otherwise time out
    start = 1'b1;
    expect_seq("late_clear", 1, 1, 0, 0);
    start = 1'b0;
    expect_seq("late_clear", 1, 3, 0, 0);
    expect_seq("late_settle", 2, 5, 0, 0);
    expect_seq("late_arm", 3, 16, 0, 0);
    valid = 1'b1;
    expect_seq("late_lock_run", 4, 2, 0, 0);

    // Asynchronous reset between edges while running
    rst_n = 1'b0;
    #1;
    push_exp(0, 0, 0);
    compare("async_reset");
    rst_n = 1'b1;
    expect_seq("idle_after_async", 0, 3, 0, 0);

    // stop during SETTLE
    start = 1'b1;
    expect_seq("stopset_clear", 1, 1, 0, 0);
    start = 1'b0;
    expect_seq("stopset_clear", 1, 3, 0, 0);
    expect_seq("stopset_settle", 2, 2, 0, 0);
    stop = 1'b1;
    expect_seq("stop_settle", 0, 1, 0, 0);
    stop = 1'b0;
    expect_seq("idle_final", 0, 2, 0, 0);

    // final report
    check_eq("exp_q_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/link_sequencer.md
# link_sequencer

Control-side stage that sits upstream of the transmitter and receiver pair and drives their `ctr_clr`, `ctr_en` and `conv_en_n` inputs. It replaces manual power-up sequencing with a Moore state machine: clear, settle, arm converters, wait for the receiver's `valid`. Once the link is up it monitors `valid`, counts dropouts, retries the bring-up a bounded number of times, and latches a fault when retries run out.

## Interface
- `CLR_CYCLES`, default 4: cycles `ctr_clr` is held high (≥1).
- `SETTLE_CYCLES`, default 5: cycles the counter runs before converters are enabled (≥1).
- `LOCK_TIMEOUT`, default 16: maximum ARM cycles to wait for `valid` (≥1).
- `DROP_LIMIT`, default 3: consecutive low-`valid` cycles in RUN that force a re-lock (≥1).
- `MAX_RETRIES`, default 3: re-lock attempts before FAULT (0..15).
- `ERR_W`, default 8: width of the dropout counter.

- `clk` in 1: system clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `start` in 1: begin bring-up; sampled only in IDLE.
- `stop` in 1: return to IDLE; highest priority.
- `valid` in 1: receiver valid flag.
- `ctr_clr` out 1: counter clear to transmitter.
- `ctr_en` out 1: counter enable to transmitter.
- `conv_en_n` out 1: active-low converter enable to transmitter and receiver.
- `locked` out 1: high in RUN only.
- `fault` out 1: high in FAULT only.
- `busy` out 1: high in any state except IDLE and FAULT.
- `retry_cnt` out 4: number of re-lock attempts since the last start.
- `drop_cnt` out ERR_W: saturating count of low-`valid` cycles seen in RUN.

## Operation
- States: IDLE, CLEAR, SETTLE, ARM, RUN, FAULT. Every output is registered and is a function of the state register only (Moore).
- Outputs by state:
  - IDLE/FAULT: `ctr_clr`=0, `ctr_en`=0, `conv_en_n`=1.
  - CLEAR: `ctr_clr`=1, `ctr_en`=0, `conv_en_n`=1.
  - SETTLE: `ctr_clr`=0, `ctr_en`=1, `conv_en_n`=1.
  - ARM/RUN: `ctr_clr`=0, `ctr_en`=1, `conv_en_n`=0.
- IDLE: `start`=1 goes to CLEAR. On that transition `retry_cnt` and `drop_cnt` both clear to 0.
- CLEAR: after exactly CLR_CYCLES cycles, go to SETTLE.
- SETTLE: after exactly SETTLE_CYCLES cycles, go to ARM.
- ARM: `valid`=1 in any ARM cycle goes to RUN. If `valid` is not seen within LOCK_TIMEOUT cycles, it is a lock failure.
- RUN: each cycle with `valid`=0 increments `drop_cnt`, saturating at 2^ERR_W−1. DROP_LIMIT consecutive low cycles is a lock failure. The consecutive-low run counter resets on any `valid`=1 cycle.
- Lock failure handling:
  - If `retry_cnt` < MAX_RETRIES: increment `retry_cnt` and go to CLEAR.
  - Otherwise go to FAULT.
- FAULT: sticky. `start` is ignored; only `stop` or reset leaves FAULT.
- `stop`=1 in any state goes to IDLE on the next edge and overrides every other transition. Counters hold their values.
- Reset state: IDLE, `ctr_clr`=0, `ctr_en`=0, `conv_en_n`=1, `locked`=0, `fault`=0, `busy`=0, `retry_cnt`=0, `drop_cnt`=0, all internal timers 0.

## Timing
- `start` high at edge N: CLEAR outputs are visible after edge N (one-cycle latency). `ctr_clr` is high for exactly CLR_CYCLES cycles.
- Earliest `conv_en_n` fall is CLR_CYCLES+SETTLE_CYCLES cycles after the start edge.
- `valid` high at the same edge that would trigger the ARM timeout: `valid` wins and the block goes to RUN.
- `valid` low on the DROP_LIMIT-th cycle together with `stop`: `stop` wins. `drop_cnt` still counts that cycle.
- One shared down-counter serves as the state timer. It is reloaded on every state entry. Its width is `$clog2` of the largest of CLR_CYCLES, SETTLE_CYCLES, LOCK_TIMEOUT, DROP_LIMIT, plus 1.
- `rst_n` asserted mid-operation: all outputs return to reset values immediately (asynchronous). Release is synchronous to the next edge.

## Structure
- Shared package `link_pkg`: state encoding localparams (IDLE=0, CLEAR=1, SETTLE=2, ARM=3, RUN=4, FAULT=5) and the 4-bit retry width constant.
- One sub-module is natural: `sat_counter`, parameterised width, with enable and synchronous clear, saturating at all-ones. It is used for `drop_cnt`.
- The FSM, timer and retry logic live in `link_sequencer`.

## Test plan
- Reset then `start` pulse with defaults and `valid` tied to 1: `ctr_clr` high for 4 cycles, then `ctr_en` rises. `conv_en_n` falls 9 cycles after the start edge, `locked`=1 on the next cycle, `retry_cnt`=0.
- `valid` held 0 throughout: three CLEAR→SETTLE→ARM cycles with `retry_cnt` 1, 2, 3, then `fault`=1 and `busy`=0. A later `start` has no effect; `stop` returns to IDLE.
- In RUN, `valid` low for 2 cycles then high: `drop_cnt`=2, `locked` stays 1. Low for 3 consecutive cycles: goes to CLEAR with `retry_cnt`=1, `drop_cnt`=5.
- ERR_W=2 with `valid` toggling low 5 times in RUN: `drop_cnt` saturates at 3.
- `valid` rises on the 16th ARM cycle: goes to RUN, no retry. `stop` asserted during SETTLE: IDLE next cycle, `ctr_en`=0, `conv_en_n`=1.
- `rst_n` pulled low mid-RUN between clock edges: all outputs reach reset values before the next edge. After release, the block idles until `start`.
